// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register file.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    OKAY   = RESP_OKAY,
    SLVERR = RESP_SLVERR
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_wstrb_merge.sv
// Byte-lane merge: each byte comes from new_i where its strobe is set,
// otherwise from old_i.
module axi4_lite_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (strb_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS byte-writable registers, with independent
// write (AW/W/B) and read (AR/R) state machines.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDXW  = $clog2(NUM_REGS);

  wr_state_t wrState_q, wrState_d;
  rd_state_t rdState_q, rdState_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [ADDR_WIDTH-1:0] awAddr_q;
  logic [DATA_WIDTH-1:0] wData_q;
  logic [BYTES-1:0]      wStrb_q;
  resp_t                 bResp_q;
  resp_t                 rResp_q;
  logic [DATA_WIDTH-1:0] rData_q;

  logic                  awHs, wHs, bHs, arHs, rHs, commit;
  logic [ADDR_WIDTH-1:0] wAddr;
  logic [DATA_WIDTH-1:0] wDataSel, mergedData;
  logic [BYTES-1:0]      wStrbSel;
  logic [IDXW-1:0]       wIdx, rIdx;
  logic                  wInRange, rInRange;
  logic                  unusedAddrBits;

  // Readies are forced low during reset so they only appear once it is released.
  assign AWREADY = !ARESET && (wrState_q == W_IDLE || wrState_q == W_HAVE_W);
  assign WREADY  = !ARESET && (wrState_q == W_IDLE || wrState_q == W_HAVE_AW);
  assign ARREADY = !ARESET && (rdState_q == R_IDLE);
  assign BVALID  = (wrState_q == W_RESP);
  assign RVALID  = (rdState_q == R_DATA);
  assign BRESP   = bResp_q;
  assign RRESP   = rResp_q;
  assign RDATA   = rData_q;

  assign awHs = AWVALID && AWREADY;
  assign wHs  = WVALID && WREADY;
  assign bHs  = BVALID && BREADY;
  assign arHs = ARVALID && ARREADY;
  assign rHs  = RVALID && RREADY;

  // A channel completing on the commit edge has not been latched yet.
  assign wAddr    = (wrState_q == W_HAVE_AW) ? awAddr_q : AWADDR;
  assign wDataSel = (wrState_q == W_HAVE_W)  ? wData_q  : WDATA;
  assign wStrbSel = (wrState_q == W_HAVE_W)  ? wStrb_q  : WSTRB;

  assign wIdx     = wAddr[LSB +: IDXW];
  assign rIdx     = ARADDR[LSB +: IDXW];
  assign wInRange = (wAddr[ADDR_WIDTH-1:LSB+IDXW] == '0);
  assign rInRange = (ARADDR[ADDR_WIDTH-1:LSB+IDXW] == '0);
  assign unusedAddrBits = ^{wAddr[LSB-1:0], ARADDR[LSB-1:0]};

  axi4_lite_wstrb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_i    (regs_q[wIdx]),
    .new_i    (wDataSel),
    .strb_i   (wStrbSel),
    .merged_o (mergedData)
  );

  always_comb begin
    wrState_d = wrState_q;
    unique case (wrState_q)
      W_IDLE: begin
        if (awHs && wHs) wrState_d = W_RESP;
        else if (awHs)   wrState_d = W_HAVE_AW;
        else if (wHs)    wrState_d = W_HAVE_W;
      end
      W_HAVE_AW: if (wHs)  wrState_d = W_RESP;
      W_HAVE_W:  if (awHs) wrState_d = W_RESP;
      W_RESP:    if (bHs)  wrState_d = W_IDLE;
      default:             wrState_d = W_IDLE;
    endcase
  end

  assign commit = (wrState_d == W_RESP) && (wrState_q != W_RESP);

  always_comb begin
    rdState_d = rdState_q;
    unique case (rdState_q)
      R_IDLE:  if (arHs) rdState_d = R_DATA;
      R_DATA:  if (rHs)  rdState_d = R_IDLE;
      default:           rdState_d = R_IDLE;
    endcase
  end

  // Reads sample regs_q before this edge's write lands, so a colliding read sees the old value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wrState_q <= W_IDLE;
      rdState_q <= R_IDLE;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      bResp_q   <= OKAY;
      rResp_q   <= OKAY;
      rData_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wrState_q <= wrState_d;
      rdState_q <= rdState_d;
      if (awHs) awAddr_q <= AWADDR;
      if (wHs) begin
        wData_q <= WDATA;
        wStrb_q <= WSTRB;
      end
      if (commit) begin
        bResp_q <= wInRange ? OKAY : SLVERR;
        if (wInRange) regs_q[wIdx] <= mergedData;
      end
      if (arHs) begin
        rResp_q <= rInRange ? OKAY : SLVERR;
        rData_q <= rInRange ? regs_q[rIdx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed self-checking bench for axi4_lite_regfile (default 32-bit, 16 regs).
module tb_axi4_lite_regfile;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_regfile dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  // Full write with AW and W together, BREADY raised once BVALID appears.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    bit awFire, wFire, got;
    resp = 2'bxx;
    got  = 0;
    @(negedge ACLK);
    AWADDR = a; AWVALID = 1; WDATA = d; WSTRB = s; WVALID = 1;
    for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
      awFire = AWVALID && AWREADY;
      wFire  = WVALID && WREADY;
      tick();
      if (awFire) AWVALID = 0;
      if (wFire)  WVALID = 0;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      if (BVALID) begin
        resp = BRESP; BREADY = 1; tick(); BREADY = 0; got = 1;
      end else tick();
    end
    if (!got || AWVALID || WVALID) begin
      checks++; errors++;
      $display("[TB] FAIL write_timeout addr=%h: got no response, required BVALID", a);
      AWVALID = 0; WVALID = 0;
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit fire, got;
    d = 'x; resp = 2'bxx; got = 0;
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1;
    for (int i = 0; i < 20 && ARVALID; i++) begin
      fire = ARREADY;
      tick();
      if (fire) ARVALID = 0;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      if (RVALID) begin
        d = RDATA; resp = RRESP; RREADY = 1; tick(); RREADY = 0; got = 1;
      end else tick();
    end
    if (!got || ARVALID) begin
      checks++; errors++;
      $display("[TB] FAIL read_timeout addr=%h: got no data, required RVALID", a);
      ARVALID = 0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    ARESET = 1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, required 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if ({BRESP, RRESP, RDATA} !== 36'h0) begin
      errors++;
      $display("[TB] FAIL reset_payload: got BRESP=%b RRESP=%b RDATA=%h, required zeros", BRESP, RRESP, RDATA);
    end
    ARESET = 0;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b, required 111", {AWREADY, WREADY, ARREADY});
    end
    do_read(32'h0, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_reg0: got %h/%b, required 00000000/00", d, r);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge ACLK);
    AWADDR = 32'h4; AWVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1;
    checks++;
    if (!(AWREADY && WREADY)) begin
      errors++;
      $display("[TB] FAIL same_ready: got AWREADY=%b WREADY=%b, required 1 1", AWREADY, WREADY);
    end
    tick();
    AWVALID = 0; WVALID = 0;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      errors++;
      $display("[TB] FAIL same_bvalid_latency: got BVALID=%b BRESP=%b, required 1 00", BVALID, BRESP);
    end
    BREADY = 1; tick(); BREADY = 0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_bvalid_clear: got %b, required 0", BVALID);
    end
    do_read(32'h4, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL same_readback: got %h/%b, required deadbeef/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge ACLK);
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1;
    tick();
    WVALID = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({AWREADY, WREADY, BVALID} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL w_first_hold cyc%0d: got AWREADY/WREADY/BVALID=%b, required 100", i, {AWREADY, WREADY, BVALID});
      end
      if (i < 2) tick();
    end
    AWADDR = 32'h8; AWVALID = 1;
    tick();
    AWVALID = 0;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      errors++;
      $display("[TB] FAIL w_first_bvalid: got %b/%b, required 1/00", BVALID, BRESP);
    end
    BREADY = 1; tick(); BREADY = 0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL w_first_single_b: got BVALID=%b, required 0", BVALID);
    end
    do_read(32'h8, d, r);
    checks++;
    if (d !== 32'h12345678 || r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL w_first_readback: got %h/%b, required 12345678/00", d, r);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(32'h0, 32'hFFFFFFFF, 4'hF, r);
    do_write(32'h0, 32'h00000000, 4'h5, r);
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL strobe_bresp: got %b, required 00", r);
    end
    do_read(32'h0, d, r);
    checks++;
    if (d !== 32'hFF00FF00) begin
      errors++;
      $display("[TB] FAIL strobe_merge: got %h, required ff00ff00", d);
    end
    do_write(32'h0, 32'h12345678, 4'h0, r);
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL zero_strobe_bresp: got %b, required 00", r);
    end
    do_read(32'h0, d, r);
    checks++;
    if (d !== 32'hFF00FF00) begin
      errors++;
      $display("[TB] FAIL zero_strobe_keep: got %h, required ff00ff00", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(32'h40, 32'hAAAA5555, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("[TB] FAIL oor_bresp: got %b, required 10", r);
    end
    do_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++;
      $display("[TB] FAIL oor_read: got %h/%b, required 00000000/10", d, r);
    end
    do_read(32'h0, d, r);
    checks++;
    if (d !== 32'hFF00FF00 || r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL oor_alias_untouched: got %h/%b, required ff00ff00/00", d, r);
    end
    do_read(32'h7, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL unaligned_read: got %h/%b, required deadbeef/00", d, r);
    end
  endtask

  task automatic test_backpressure();
    @(negedge ACLK);
    AWADDR = 32'hC; AWVALID = 1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    ARADDR = 32'hC; ARVALID = 1;
    checks++;
    if (ARREADY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_arready_during_b: got %b, required 1", ARREADY);
    end
    tick();
    ARVALID = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
        errors++;
        $display("[TB] FAIL bp_write_hold cyc%0d: got BVALID/BRESP/AWREADY/WREADY=%b, required 10000", i, {BVALID, BRESP, AWREADY, WREADY});
      end
      checks++;
      if (RVALID !== 1'b1 || RDATA !== 32'hCAFEF00D || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_read_hold cyc%0d: got RVALID=%b RDATA=%h RRESP=%b ARREADY=%b, required 1 cafef00d 00 0", i, RVALID, RDATA, RRESP, ARREADY);
      end
      tick();
    end
    BREADY = 1; RREADY = 1;
    tick();
    BREADY = 0; RREADY = 0;
    checks++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b00111) begin
      errors++;
      $display("[TB] FAIL bp_release: got %b, required 00111", {BVALID, RVALID, AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge ACLK);
    AWADDR = 32'h4; AWVALID = 1; WDATA = 32'h11111111; WSTRB = 4'hF; WVALID = 1;
    ARADDR = 32'h4; ARVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF || BVALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collision_old_value: got RVALID=%b RDATA=%h BVALID=%b, required 1 deadbeef 1", RVALID, RDATA, BVALID);
    end
    BREADY = 1; RREADY = 1; tick(); BREADY = 0; RREADY = 0;
    do_read(32'h4, d, r);
    checks++;
    if (d !== 32'h11111111) begin
      errors++;
      $display("[TB] FAIL collision_new_value: got %h, required 11111111", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] vals [3] = '{32'h0F0F0F0F, 32'hA5A5A5A5, 32'h00C0FFEE};
    logic [31:0] addrs [3] = '{32'h3C, 32'h20, 32'h24};
    for (int i = 0; i < 3; i++) do_write(addrs[i], vals[i], 4'hF, r);
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], d, r);
      checks++;
      if (d !== vals[i] || r !== 2'b00) begin
        errors++;
        $display("[TB] FAIL b2b_readback addr=%h: got %h/%b, required %h/00", addrs[i], d, r, vals[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge ACLK);
    AWADDR = 32'h10; AWVALID = 1;
    tick();
    AWVALID = 0;
    ARESET = 1;
    tick();
    ARESET = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (BVALID !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_reset_no_b cyc%0d: got %b, required 0", i, BVALID);
      end
      tick();
    end
    do_read(32'h10, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_target: got %h, required 00000000", d);
    end
    do_write(32'h10, 32'h0BADCAFE, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mid_reset_next_bresp: got %b, required 00", r);
    end
    do_read(32'h10, d, r);
    checks++;
    if (d !== 32'h0BADCAFE) begin
      errors++;
      $display("[TB] FAIL mid_reset_next_data: got %h, required 0badcafe", d);
    end
  endtask

  initial begin
    ARESET = 1; AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
    BREADY = 0; ARADDR = '0; ARVALID = 0; RREADY = 0;
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_regfile.md
AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width in bits; SHALL be 32 or 64.
REQ-002 Parameter ADDR_WIDTH, 32, address bus width in bits.
REQ-003 Parameter NUM_REGS, 16, number of DATA_WIDTH-bit registers; SHALL be a power of two, 2..256.
REQ-004 Ports SHALL be as follows; one clock, and reset is synchronous and active-high:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  synchronous active-high reset.
AWADDR  in  ADDR_WIDTH  write address; AWVALID in 1; AWREADY out 1.
WDATA  in  DATA_WIDTH  write data; WSTRB in DATA_WIDTH/8 byte strobes; WVALID in 1; WREADY out 1.
BRESP  out  2  write response; BVALID out 1; BREADY in 1.
ARADDR  in  ADDR_WIDTH  read address; ARVALID in 1; ARREADY out 1.
RDATA  out  DATA_WIDTH  read data; RRESP out 2; RVALID out 1; RREADY in 1.

Function
REQ-005 A handshake SHALL occur at a rising edge where VALID and READY are both 1.
REQ-006 Byte lanes SHALL be BYTES = DATA_WIDTH/8; LSB = log2(BYTES); register index SHALL be addr[LSB +: log2(NUM_REGS)]; addr[LSB-1:0] SHALL be ignored.
REQ-007 An address SHALL be in range iff addr < NUM_REGS*BYTES; otherwise the response SHALL be SLVERR (2'b10), and in-range responses SHALL be OKAY (2'b00).
REQ-008 AW and W SHALL be accepted independently in any order or the same cycle; each channel SHALL latch its payload on handshake.
REQ-009 AWREADY SHALL be 1 only while no AW is held and BVALID=0; WREADY SHALL be 1 only while no W is held and BVALID=0.
REQ-010 On the edge at which both AW and W are held (or complete), byte i of the target register SHALL be updated iff WSTRB[i]=1 and the address is in range; out-of-range writes SHALL modify nothing.
REQ-011 BVALID SHALL rise the cycle after that edge (write latency 1) and SHALL hold BVALID/BRESP stable until BREADY handshake; held AW/W SHALL clear on that handshake.
REQ-012 Write FSM states SHALL be W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP: IDLE->HAVE_AW on AW only, IDLE->HAVE_W on W only, IDLE/HAVE_*->RESP when both complete, RESP->IDLE on B handshake.
REQ-013 ARREADY SHALL be 1 iff RVALID=0; on AR handshake RDATA/RRESP SHALL be loaded and RVALID SHALL rise the next cycle (read latency 1).
REQ-014 RDATA SHALL be 0 for out-of-range reads; RVALID/RDATA/RRESP SHALL hold stable until R handshake.
REQ-015 Read FSM states SHALL be R_IDLE, R_DATA: IDLE->DATA on AR handshake, DATA->IDLE on R handshake.
REQ-016 When an AR handshake and a write commit to the same register occur on the same edge, RDATA SHALL return the pre-write value.
REQ-017 Read and write paths SHALL operate concurrently with no mutual stall.
REQ-018 WSTRB=0 with an in-range address SHALL return OKAY and leave the register unchanged.

Reset
REQ-019 While ARESET=1 at a rising edge, all registers, held AW/W state, and AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP and RDATA SHALL be 0; both FSMs SHALL go to IDLE.
REQ-020 A reset mid-transaction SHALL discard it with no write commit or response; READY signals SHALL assert from the first cycle after reset deasserts.

Structure
REQ-021 Package axi4_lite_pkg SHALL hold resp_t (OKAY, SLVERR), the wr_state_t/rd_state_t enums, and the RESP_OKAY/RESP_SLVERR constants.
REQ-022 The byte-strobe merge SHALL be one sub-module, axi4_lite_wstrb_merge (old, new, strobe -> merged); the remaining logic SHALL be flat.

Verification
REQ-023 Write addr 0x4, data 0xDEADBEEF, WSTRB 0xF, AW and W in same cycle -> BVALID 1 cycle later, BRESP=0; read 0x4 -> RDATA 0xDEADBEEF, RRESP=0.
REQ-024 W sent 3 cycles before AW (addr 0x8, 0x12345678) -> AWREADY stays 1, WREADY=0 after W; one BVALID after AW; readback 0x12345678.
REQ-025 Reg 0x0 = 0xFFFFFFFF; write 0x00000000 with WSTRB 0x5 -> readback 0xFF00FF00.
REQ-026 Write/read addr NUM_REGS*4 (0x40) -> BRESP=SLVERR, RRESP=SLVERR, RDATA 0; no register changed.
REQ-027 BREADY/RREADY held 0 for 5 cycles -> BVALID/RVALID and payloads stable; AWREADY=WREADY=0 and ARREADY=0 throughout.
REQ-028 ARESET pulsed after AW handshake but before W -> no BVALID; target register unchanged; next full write completes normally.
